// File: rtl/seq_divider16_pkg.sv
// seq_divider16_pkg: shared definitions for the iterative divider.
//   state_t       - FSM encoding (IDLE / CALC / DONE)
//   DEF_WIDTH     - default operand/result width
//   DEF_AW        - default register-index width
//   DIV0_QUOTIENT - quotient reported on divide by zero (all ones)
package seq_divider16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AW    = 3;

    localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider16_div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  - current partial remainder (always < divisor)
//   dvd_msb - next dividend bit shifted into the remainder
//   divisor - divisor magnitude
//   rem_out - next partial remainder
//   q_bit   - quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor, so shifted < 2*divisor and fits WIDTH+1 bits.
    // A wrapped (negative) difference always lands with its MSB set,
    // while a valid one is < divisor, so diff[WIDTH] is the borrow.
    assign shifted = {rem_in, dvd_msb};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider16.sv
// seq_divider16: iterative signed/unsigned divider, one quotient bit per
// clock, finishing with a one-cycle register-file write-back strobe.
//   clk, rst           - clock, async active-high reset
//   start              - request, accepted in IDLE or DONE
//   signed_op, sel_rem - two's-complement mode, write remainder vs quotient
//   dividend, divisor  - operands; rd - destination register
//   busy               - high while iterating
//   done               - one-cycle completion pulse (== wb_we)
//   quotient, remainder, div_by_zero - last result, held until next done
//   wb_we, wb_addr, wb_data          - register-file write port
module seq_divider16
    import seq_divider16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             sel_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [AW-1:0]    rd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             wb_we,
    output logic [AW-1:0]    wb_addr,
    output logic [WIDTH-1:0] wb_data
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DIV0_Q = WIDTH'(DIV0_QUOTIENT);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;   // dividend shifts out MSB-first, quotient fills LSB
    logic [WIDTH-1:0] dsr_r;
    logic             q_neg;
    logic             r_neg;
    logic             sel_rem_r;
    logic [AW-1:0]    rd_r;

    logic             dvd_neg, dsr_neg, dsr_zero;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic [WIDTH-1:0] step_rem, q_next, q_fin, r_fin;
    logic             step_q;

    assign dvd_neg  = signed_op & dividend[WIDTH-1];
    assign dsr_neg  = signed_op & divisor[WIDTH-1];
    assign dvd_mag  = dvd_neg ? -dividend : dividend;
    assign dsr_mag  = dsr_neg ? -divisor  : divisor;
    assign dsr_zero = (divisor == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .dvd_msb (dvd_r[WIDTH-1]),
        .divisor (dsr_r),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // -32768 / -1 yields magnitude 16'h8000 with q_neg=0, which is the
    // natural wrapped result, so no special case is needed.
    assign q_next = {dvd_r[WIDTH-2:0], step_q};
    assign q_fin  = q_neg ? -q_next : q_next;
    assign r_fin  = r_neg ? -step_rem : step_rem;

    assign busy  = (state == CALC);
    assign wb_we = done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            dvd_r       <= '0;
            dsr_r       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            sel_rem_r   <= 1'b0;
            rd_r        <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rem_r     <= '0;
                        dvd_r     <= dvd_mag;
                        dsr_r     <= dsr_mag;
                        q_neg     <= dvd_neg ^ dsr_neg;
                        r_neg     <= dvd_neg;
                        sel_rem_r <= sel_rem;
                        rd_r      <= rd;
                        if (dsr_zero) begin
                            // Divide by zero skips CALC; remainder is the raw dividend.
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= DIV0_Q;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            wb_addr     <= rd;
                            wb_data     <= sel_rem ? dividend : DIV0_Q;
                        end else begin
                            state <= CALC;
                            cnt   <= CW'(WIDTH - 1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem_r <= step_rem;
                    dvd_r <= q_next;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= q_fin;
                        remainder   <= r_fin;
                        div_by_zero <= 1'b0;
                        wb_addr     <= rd_r;
                        wb_data     <= sel_rem_r ? r_fin : q_fin;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider16.sv
// tb_seq_divider16: directed self-checking bench for seq_divider16.
module tb_seq_divider16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, signed_op, sel_rem;
    logic [15:0] dividend, divisor;
    logic [2:0]  rd;
    logic        busy, done, div_by_zero, wb_we;
    logic [15:0] quotient, remainder, wb_data;
    logic [2:0]  wb_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int lat, bcnt, wcnt;

    always #5 clk = ~clk;

    seq_divider16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .sel_rem     (sel_rem),
        .dividend    (dividend),
        .divisor     (divisor),
        .rd          (rd),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request from a negedge; returns just after the accepting edge.
    task automatic launch(input logic s, input logic sr, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] r);
        signed_op = s; sel_rem = sr; dividend = a; divisor = b; rd = r;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done; optionally injects
    // a stray start at negedge number inj.
    task automatic wait_done(input int inj, output int l, output int bc);
        l = 0; bc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) bc++;
            if (n == inj) begin
                start = 1'b1; signed_op = 1'b0; sel_rem = 1'b1;
                dividend = 16'd9; divisor = 16'd3; rd = 3'd7;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                l = n;
                break;
            end
        end
        if (l == 0) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; sel_rem = 1'b0;
        dividend = '0; divisor = '0; rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wbwe", wb_we, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_data", wb_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7 unsigned, quotient write-back to r3
        launch(0, 0, 16'd100, 16'd7, 3'd3);
        wait_done(0, lat, bcnt);
        chk("u_lat", lat, 17);
        chk("u_busy", bcnt, 16);
        chk("u_q", quotient, 16'd14);
        chk("u_r", remainder, 16'd2);
        chk("u_we", wb_we, 1);
        chk("u_addr", wb_addr, 3);
        chk("u_data", wb_data, 16'h000E);
        chk("u_dbz", div_by_zero, 0);
        @(negedge clk);
        chk("u_done1", done, 0);

        // -100 / 7 signed, remainder write-back
        launch(1, 1, 16'hFF9C, 16'd7, 3'd5);
        wait_done(0, lat, bcnt);
        chk("s_q", quotient, 16'hFFF2);
        chk("s_r", remainder, 16'hFFFE);
        chk("s_data", wb_data, 16'hFFFE);
        chk("s_addr", wb_addr, 5);
        @(negedge clk);

        // 0xFF9C = 65436 = 7 * 9348 exactly in unsigned mode
        launch(0, 0, 16'hFF9C, 16'd7, 3'd1);
        wait_done(0, lat, bcnt);
        chk("uff_q", quotient, 16'h2484);
        chk("uff_r", remainder, 16'h0000);
        @(negedge clk);

        // 7 / -2 signed -> -3 rem 1
        launch(1, 0, 16'd7, 16'hFFFE, 3'd2);
        wait_done(0, lat, bcnt);
        chk("sd_q", quotient, 16'hFFFD);
        chk("sd_r", remainder, 16'h0001);
        @(negedge clk);

        // 1234 / 0
        launch(0, 0, 16'd1234, 16'd0, 3'd4);
        wait_done(0, lat, bcnt);
        chk("z_lat", lat, 1);
        chk("z_busy", bcnt, 0);
        chk("z_q", quotient, 16'hFFFF);
        chk("z_r", remainder, 16'h04D2);
        chk("z_dbz", div_by_zero, 1);
        chk("z_we", wb_we, 1);
        chk("z_addr", wb_addr, 4);
        chk("z_data", wb_data, 16'hFFFF);
        @(negedge clk);

        // signed -5 / 0, remainder is raw dividend
        launch(1, 1, 16'hFFFB, 16'd0, 3'd6);
        wait_done(0, lat, bcnt);
        chk("zs_r", remainder, 16'hFFFB);
        chk("zs_data", wb_data, 16'hFFFB);
        @(negedge clk);

        // -32768 / -1 wraps, no flag
        launch(1, 0, 16'h8000, 16'hFFFF, 3'd1);
        wait_done(0, lat, bcnt);
        chk("ov_q", quotient, 16'h8000);
        chk("ov_r", remainder, 16'h0000);
        chk("ov_dbz", div_by_zero, 0);
        @(negedge clk);

        // stray start during CALC is ignored
        launch(0, 0, 16'd1000, 16'd10, 3'd2);
        wait_done(5, lat, bcnt);
        chk("ig_lat", lat, 17);
        chk("ig_q", quotient, 16'd100);
        chk("ig_r", remainder, 16'd0);
        chk("ig_addr", wb_addr, 2);
        chk("ig_data", wb_data, 16'd100);

        // back-to-back: start held in the DONE cycle
        launch(1, 1, 16'hFFF9, 16'd2, 3'd6);
        wait_done(0, lat, bcnt);
        chk("bb_lat", lat, 17);
        chk("bb_q", quotient, 16'hFFFD);
        chk("bb_r", remainder, 16'hFFFF);
        chk("bb_addr", wb_addr, 6);
        @(negedge clk);

        // reset mid-CALC aborts with no write-back
        launch(0, 0, 16'd500, 16'd3, 3'd5);
        repeat (8) @(negedge clk);
        chk("ab_busy0", busy, 1);
        rst = 1'b1;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_we", wb_we, 0);
        chk("ab_q", quotient, 0);
        chk("ab_r", remainder, 0);
        chk("ab_data", wb_data, 0);
        @(negedge clk);
        rst = 1'b0;
        wcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (wb_we) wcnt++;
        end
        chk("ab_nowb", wcnt, 0);

        launch(0, 0, 16'd50, 16'd5, 3'd3);
        wait_done(0, lat, bcnt);
        chk("pr_lat", lat, 17);
        chk("pr_q", quotient, 16'd10);
        chk("pr_r", remainder, 16'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
